pll_lock_reset_sequencer: RTL and testbench

//  Multi-channel reset manager for the PLL clock domains (SDRAM, CPU and peripheral PLLs).

---
 rtl/pll_lock_reset_sequencer.sv | 134 +++++++++++++
 tb/tb_pll_lock_reset_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_reset_sequencer.sv
// PLL reset/lock supervisor: retries the PLL until lock is stable, then releases
// NUM_CH downstream resets in order and slams them all back on loss of lock.
module pll_lock_reset_sequencer #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned PLL_RST_CYCLES = 8,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned STAGE_GAP      = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic              clear_count,
  output logic              pll_rst_out,
  output logic [NUM_CH-1:0] rst_out,
  output logic              all_ready,
  output logic [CNT_W-1:0]  retry_count,
  output logic [CNT_W-1:0]  lock_loss_count
);

  localparam int unsigned REL_SPAN = STAGE_GAP * NUM_CH;
  localparam int unsigned MAX_AB   = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int unsigned MAX_ABC  = (MAX_AB > REL_SPAN) ? MAX_AB : REL_SPAN;
  localparam int unsigned MAX_ALL  = (MAX_ABC > PLL_RST_CYCLES) ? MAX_ABC : PLL_RST_CYCLES;
  localparam int unsigned TW       = $clog2(MAX_ALL) + 1;

  localparam logic [TW-1:0]    RST_LAST     = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0]    TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0]    STABLE_LAST  = TW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0]    RUN_AT       = TW'(STAGE_GAP * (NUM_CH - 1));
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN
  } state_t;

  state_t                 state, state_d;
  logic [TW-1:0]          timer, timer_d;
  logic [NUM_CH-1:0]      rst_out_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lk;
  logic                   retry_inc, loss_inc;
  logic [CNT_W-1:0]       retry_d, loss_d;

  assign lk          = sync_q[SYNC_STAGES-1];
  assign pll_rst_out = (state == PLL_RST);
  assign all_ready   = (state == RUN) && (rst_out == '0);

  always_ff @(posedge refclk) begin
    if (rst) begin
      state           <= PLL_RST;
      timer           <= '0;
      rst_out         <= '1;
      sync_q          <= '0;
      retry_count     <= '0;
      lock_loss_count <= '0;
    end else begin
      state           <= state_d;
      timer           <= timer_d;
      rst_out         <= rst_out_d;
      sync_q          <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      retry_count     <= retry_d;
      lock_loss_count <= loss_d;
    end
  end

  always_comb begin
    state_d   = state;
    rst_out_d = rst_out;
    retry_inc = 1'b0;
    loss_inc  = 1'b0;
    unique case (state)
      PLL_RST: begin
        rst_out_d = '1;
        if (timer == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lk) begin
          state_d = STABLE;
        end else if (timer == TIMEOUT_LAST) begin
          retry_inc = 1'b1;
          state_d   = PLL_RST;
        end
      end
      STABLE: begin
        if (!lk) begin
          state_d = WAIT_LOCK;
        end else if (timer == STABLE_LAST) begin
          state_d      = RELEASE;
          rst_out_d[0] = 1'b0;
        end
      end
      RELEASE: begin
        if (!lk) begin
          loss_inc  = 1'b1;
          rst_out_d = '1;
          state_d   = PLL_RST;
        end else begin
          // bit k drops STAGE_GAP*k edges after bit 0, whose drop was the entry edge
          for (int unsigned k = 1; k < NUM_CH; k++) begin
            if (timer == TW'(STAGE_GAP * k - 1)) rst_out_d[k] = 1'b0;
          end
          if (timer == RUN_AT) state_d = RUN;
        end
      end
      RUN: begin
        if (!lk) begin
          loss_inc  = 1'b1;
          rst_out_d = '1;
          state_d   = PLL_RST;
        end
      end
      default: begin
        state_d   = PLL_RST;
        rst_out_d = '1;
      end
    endcase

    timer_d = ((state_d != state) || (state == RUN)) ? '0 : timer + 1'b1;

    // clear first, then count, so a coincident clear and increment yields 1
    retry_d = clear_count ? '0 : retry_count;
    if (retry_inc && (retry_d != CNT_MAX)) retry_d = retry_d + 1'b1;
    loss_d = clear_count ? '0 : lock_loss_count;
    if (loss_inc && (loss_d != CNT_MAX)) loss_d = loss_d + 1'b1;
  end

endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// Bench for pll_lock_reset_sequencer: table of hold/expect vectors plus timed
// corner sequences, all expectations queued and compared after each edge.
module tb_pll_lock_reset_sequencer;

  localparam int unsigned NUM_CH         = 4;
  localparam int unsigned SYNC_STAGES    = 2;
  localparam int unsigned PLL_RST_CYCLES = 4;
  localparam int unsigned LOCK_TIMEOUT   = 32;
  localparam int unsigned STABLE_CYCLES  = 8;
  localparam int unsigned STAGE_GAP      = 3;
  localparam int unsigned CNT_W          = 2;

  logic              refclk = 1'b0;
  logic              rst;
  logic              pll_locked;
  logic              clear_count;
  logic              pll_rst_out;
  logic [NUM_CH-1:0] rst_out;
  logic              all_ready;
  logic [CNT_W-1:0]  retry_count;
  logic [CNT_W-1:0]  lock_loss_count;

  pll_lock_reset_sequencer #(
    .NUM_CH        (NUM_CH),
    .SYNC_STAGES   (SYNC_STAGES),
    .PLL_RST_CYCLES(PLL_RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .STAGE_GAP     (STAGE_GAP),
    .CNT_W         (CNT_W)
  ) dut (
    .refclk         (refclk),
    .rst            (rst),
    .pll_locked     (pll_locked),
    .clear_count    (clear_count),
    .pll_rst_out    (pll_rst_out),
    .rst_out        (rst_out),
    .all_ready      (all_ready),
    .retry_count    (retry_count),
    .lock_loss_count(lock_loss_count)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    string      name;
    logic       prst;
    logic [3:0] ro;
    logic       rdy;
    logic [1:0] rc;
    logic [1:0] lc;
  } exp_t;

  typedef struct {
    int unsigned hold;
    logic        lock;
    logic        clr;
    exp_t        e;
  } vec_t;

  exp_t        sb[$];
  vec_t        tbl[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned t        = 0;

  function automatic exp_t ex(string n, logic prst, logic [3:0] ro, logic rdy,
                              logic [1:0] rc, logic [1:0] lc);
    exp_t e;
    e.name = n; e.prst = prst; e.ro = ro; e.rdy = rdy; e.rc = rc; e.lc = lc;
    return e;
  endfunction

  function automatic vec_t vv(int unsigned hold, logic lock, logic clr, exp_t e);
    vec_t v;
    v.hold = hold; v.lock = lock; v.clr = clr; v.e = e;
    return v;
  endfunction

  task automatic cmp(input string name, input string field, input logic [7:0] act,
                     input logic [7:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s.%s at edge %0d: got %0h expected %0h", name, field, t, act, req);
  endtask

  task automatic check_front();
    exp_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    cmp(e.name, "pll_rst_out", {7'd0, pll_rst_out}, {7'd0, e.prst});
    cmp(e.name, "rst_out", {4'd0, rst_out}, {4'd0, e.ro});
    cmp(e.name, "all_ready", {7'd0, all_ready}, {7'd0, e.rdy});
    cmp(e.name, "retry_count", {6'd0, retry_count}, {6'd0, e.rc});
    cmp(e.name, "lock_loss_count", {6'd0, lock_loss_count}, {6'd0, e.lc});
  endtask

  task automatic drive(input logic lock, input logic clr);
    pll_locked  = lock;
    clear_count = clr;
    @(posedge refclk);
    #1;
    t++;
    clear_count = 1'b0;
    check_front();
  endtask

  // drive `lock` through edge n, expecting e just after edge n
  task automatic at(input int unsigned n, input logic lock, input exp_t e);
    if (t >= n) begin
      n_checks++;
      $display("FAIL %s: sequence already at edge %0d, required edge %0d", e.name, t, n);
      return;
    end
    while (t < n) begin
      if (t == n - 1) sb.push_back(e);
      drive(lock, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    pll_locked  = 1'b0;
    clear_count = 1'b0;
    repeat (2) @(posedge refclk);
    #1;
    rst = 1'b0;
    t   = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // clean lock, loss in RUN, timeouts, saturation and clear-on-timeout
    tbl.push_back(vv(0,  1'b0, 1'b0, ex("reset",      1'b1, 4'hF, 1'b0, 2'd0, 2'd0)));
    tbl.push_back(vv(3,  1'b0, 1'b0, ex("t1_prst_c3", 1'b1, 4'hF, 1'b0, 2'd0, 2'd0)));
    tbl.push_back(vv(1,  1'b0, 1'b0, ex("t1_prst_c4", 1'b0, 4'hF, 1'b0, 2'd0, 2'd0)));
    tbl.push_back(vv(5,  1'b0, 1'b0, ex("t1_wait",    1'b0, 4'hF, 1'b0, 2'd0, 2'd0)));
    tbl.push_back(vv(10, 1'b1, 1'b0, ex("t1_stable",  1'b0, 4'hF, 1'b0, 2'd0, 2'd0)));
    tbl.push_back(vv(1,  1'b1, 1'b0, ex("t1_bit0",    1'b0, 4'hE, 1'b0, 2'd0, 2'd0)));
    tbl.push_back(vv(2,  1'b1, 1'b0, ex("t1_gap0",    1'b0, 4'hE, 1'b0, 2'd0, 2'd0)));
    tbl.push_back(vv(1,  1'b1, 1'b0, ex("t1_bit1",    1'b0, 4'hC, 1'b0, 2'd0, 2'd0)));
    tbl.push_back(vv(3,  1'b1, 1'b0, ex("t1_bit2",    1'b0, 4'h8, 1'b0, 2'd0, 2'd0)));
    tbl.push_back(vv(3,  1'b1, 1'b0, ex("t1_bit3",    1'b0, 4'h0, 1'b0, 2'd0, 2'd0)));
    tbl.push_back(vv(1,  1'b1, 1'b0, ex("t1_run",     1'b0, 4'h0, 1'b1, 2'd0, 2'd0)));
    tbl.push_back(vv(10, 1'b1, 1'b0, ex("t1_run_hold",1'b0, 4'h0, 1'b1, 2'd0, 2'd0)));
    tbl.push_back(vv(2,  1'b0, 1'b0, ex("t4_sync_lag",1'b0, 4'h0, 1'b1, 2'd0, 2'd0)));
    tbl.push_back(vv(1,  1'b0, 1'b0, ex("t4_loss",    1'b1, 4'hF, 1'b0, 2'd0, 2'd1)));
    tbl.push_back(vv(3,  1'b0, 1'b0, ex("t2_prst_hi", 1'b1, 4'hF, 1'b0, 2'd0, 2'd1)));
    tbl.push_back(vv(1,  1'b0, 1'b0, ex("t2_prst_lo", 1'b0, 4'hF, 1'b0, 2'd0, 2'd1)));
    tbl.push_back(vv(31, 1'b0, 1'b0, ex("t2_pre_to1", 1'b0, 4'hF, 1'b0, 2'd0, 2'd1)));
    tbl.push_back(vv(1,  1'b0, 1'b0, ex("t2_to1",     1'b1, 4'hF, 1'b0, 2'd1, 2'd1)));
    tbl.push_back(vv(3,  1'b0, 1'b0, ex("t2_pulse2",  1'b1, 4'hF, 1'b0, 2'd1, 2'd1)));
    tbl.push_back(vv(1,  1'b0, 1'b0, ex("t2_pulse2e", 1'b0, 4'hF, 1'b0, 2'd1, 2'd1)));
    tbl.push_back(vv(32, 1'b0, 1'b0, ex("t2_to2",     1'b1, 4'hF, 1'b0, 2'd2, 2'd1)));
    tbl.push_back(vv(36, 1'b0, 1'b0, ex("t2_to3",     1'b1, 4'hF, 1'b0, 2'd3, 2'd1)));
    tbl.push_back(vv(72, 1'b0, 1'b0, ex("t6_sat",     1'b1, 4'hF, 1'b0, 2'd3, 2'd1)));
    tbl.push_back(vv(35, 1'b0, 1'b0, ex("t6_pre_clr", 1'b0, 4'hF, 1'b0, 2'd3, 2'd1)));
    tbl.push_back(vv(1,  1'b0, 1'b1, ex("t6_clr_inc", 1'b1, 4'hF, 1'b0, 2'd1, 2'd0)));

    do_reset();
    foreach (tbl[i]) begin
      if (tbl[i].hold == 0) begin
        sb.push_back(tbl[i].e);
        check_front();
      end else begin
        for (int unsigned c = 0; c < tbl[i].hold; c++) begin
          if (c == tbl[i].hold - 1) sb.push_back(tbl[i].e);
          drive(tbl[i].lock, (c == 0) ? tbl[i].clr : 1'b0);
        end
      end
    end

    // one-cycle lock glitch after 5 STABLE cycles restarts the stability count
    do_reset();
    at(9,  1'b0, ex("t3_wait",     1'b0, 4'hF, 1'b0, 2'd0, 2'd0));
    at(14, 1'b1, ex("t3_locked",   1'b0, 4'hF, 1'b0, 2'd0, 2'd0));
    at(15, 1'b0, ex("t3_glitch",   1'b0, 4'hF, 1'b0, 2'd0, 2'd0));
    at(20, 1'b1, ex("t3_no_early", 1'b0, 4'hF, 1'b0, 2'd0, 2'd0));
    at(25, 1'b1, ex("t3_pre_rel",  1'b0, 4'hF, 1'b0, 2'd0, 2'd0));
    at(26, 1'b1, ex("t3_bit0",     1'b0, 4'hE, 1'b0, 2'd0, 2'd0));

    // loss of lock with only bits 0 and 1 released, then a full fresh pass
    at(28, 1'b1, ex("t5_bit0",     1'b0, 4'hE, 1'b0, 2'd0, 2'd0));
    at(29, 1'b0, ex("t5_bit1",     1'b0, 4'hC, 1'b0, 2'd0, 2'd0));
    at(30, 1'b0, ex("t5_lag",      1'b0, 4'hC, 1'b0, 2'd0, 2'd0));
    at(31, 1'b0, ex("t5_loss",     1'b1, 4'hF, 1'b0, 2'd0, 2'd1));
    at(34, 1'b1, ex("t5_prst",     1'b1, 4'hF, 1'b0, 2'd0, 2'd1));
    at(43, 1'b1, ex("t5_hold",     1'b0, 4'hF, 1'b0, 2'd0, 2'd1));
    at(44, 1'b1, ex("t5_rerel",    1'b0, 4'hE, 1'b0, 2'd0, 2'd1));
    at(47, 1'b1, ex("t6_midrel",   1'b0, 4'hC, 1'b0, 2'd0, 2'd1));

    // rst mid-RELEASE returns everything, synchroniser included, to reset values
    rst = 1'b1;
    at(48, 1'b1, ex("t6_rst",      1'b1, 4'hF, 1'b0, 2'd0, 2'd0));
    at(49, 1'b1, ex("t6_rst_hold", 1'b1, 4'hF, 1'b0, 2'd0, 2'd0));
    rst = 1'b0;
    t   = 0;
    at(12, 1'b1, ex("t6_post_pre", 1'b0, 4'hF, 1'b0, 2'd0, 2'd0));
    at(13, 1'b1, ex("t6_post_rel", 1'b0, 4'hE, 1'b0, 2'd0, 2'd0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
